// File: rtl/hazard_ctrl.sv
//============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard unit: stall/flush enables, forwarding selects
//            and mult/div busy tracking. Optional stall perf counter is
//            built when HAZ_PERF_EN is defined.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic        md_instr_D,
  input  logic [4:0]  rs_E,
  input  logic [4:0]  rt_E,
  input  logic [4:0]  dst_E,
  input  logic [2:0]  res_E,
  input  logic [2:0]  res_M,
  input  logic [2:0]  res_W,
  input  logic [4:0]  dst_M,
  input  logic [4:0]  dst_W,
  input  logic [4:0]  rt_M,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  output logic        stall,
  output logic        en_PC,
  output logic        en_D,
  output logic        flush_E,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
  output logic        fwd_rt_M,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [2:0] c_RES_NW  = 3'd0;
  localparam logic [2:0] c_RES_ALU = 3'd1;
  localparam logic [2:0] c_RES_DM  = 3'd2;
  localparam logic [2:0] c_RES_PC  = 3'd3;
  localparam logic [2:0] c_RES_MD  = 3'd4;

  localparam logic [1:0] c_FWD_NONE = 2'd0;
  localparam logic [1:0] c_FWD_E    = 2'd1;
  localparam logic [1:0] c_FWD_M    = 2'd2;
  localparam logic [1:0] c_FWD_W    = 2'd3;

  localparam logic [1:0] c_TUSE_NONE = 2'd3;

  localparam logic [CNT_W-1:0] c_MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_CYC);

  // Types 5-7 behave like NW: they never produce a register value.
  function automatic logic is_prod(input logic [2:0] res);
    return (res == c_RES_ALU) || (res == c_RES_DM) ||
           (res == c_RES_PC)  || (res == c_RES_MD);
  endfunction

  function automatic logic hit(input logic [4:0] r, input logic [4:0] dst,
                               input logic [2:0] res);
    return (dst != 5'd0) && (dst == r) && is_prod(res);
  endfunction

  function automatic logic [1:0] tnew_e(input logic [2:0] res);
    logic [1:0] t;
    case (res)
      c_RES_ALU: t = 2'd1;
      c_RES_DM:  t = 2'd2;
      c_RES_MD:  t = 2'd1;
      default:   t = 2'd0;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] tnew_m(input logic [2:0] res);
    return (res == c_RES_DM) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic ready_m(input logic [2:0] res);
    return (res == c_RES_ALU) || (res == c_RES_PC) || (res == c_RES_MD);
  endfunction

  // D operand: {stall, fwd_sel}. Youngest match decides; older ones are ignored.
  function automatic logic [2:0] d_op(
    input logic [4:0] r,  input logic [1:0] tuse,
    input logic [4:0] de, input logic [2:0] re,
    input logic [4:0] dm, input logic [2:0] rm,
    input logic [4:0] dw, input logic [2:0] rw
  );
    logic       stl;
    logic [1:0] sel;
    stl = 1'b0;
    sel = c_FWD_NONE;
    if (hit(r, de, re)) begin
      stl = (tuse != c_TUSE_NONE) && (tnew_e(re) > tuse);
      sel = (re == c_RES_PC) ? c_FWD_E : c_FWD_NONE;
    end else if (hit(r, dm, rm)) begin
      stl = (tuse != c_TUSE_NONE) && (tnew_m(rm) > tuse);
      sel = ready_m(rm) ? c_FWD_M : c_FWD_NONE;
    end else if (hit(r, dw, rw)) begin
      sel = c_FWD_W;
    end
    return {stl, sel};
  endfunction

  function automatic logic [1:0] e_op(
    input logic [4:0] r,
    input logic [4:0] dm, input logic [2:0] rm,
    input logic [4:0] dw, input logic [2:0] rw
  );
    logic [1:0] sel;
    sel = c_FWD_NONE;
    if (hit(r, dm, rm)) begin
      sel = ready_m(rm) ? c_FWD_M : c_FWD_NONE;
    end else if (hit(r, dw, rw)) begin
      sel = c_FWD_W;
    end
    return sel;
  endfunction

  logic [2:0]       w_rs_d;
  logic [2:0]       w_rt_d;
  logic             w_data_stall;
  logic             w_md_stall;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign w_rs_d = d_op(rs_D, tuse_rs_D, dst_E, res_E, dst_M, res_M, dst_W, res_W);
  assign w_rt_d = d_op(rt_D, tuse_rt_D, dst_E, res_E, dst_M, res_M, dst_W, res_W);

  assign w_data_stall = w_rs_d[2] | w_rt_d[2];
  assign md_busy      = (cnt_q != '0) | md_start_E;
  assign w_md_stall   = md_instr_D & md_busy;

  assign stall    = w_data_stall | w_md_stall;
  assign en_PC    = ~stall;
  assign en_D     = ~stall;
  assign flush_E  = stall;

  assign fwd_rs_D = w_rs_d[1:0];
  assign fwd_rt_D = w_rt_d[1:0];
  assign fwd_rs_E = e_op(rs_E, dst_M, res_M, dst_W, res_W);
  assign fwd_rt_E = e_op(rt_E, dst_M, res_M, dst_W, res_W);
  assign fwd_rt_M = hit(rt_M, dst_W, res_W);

  // A new issue always reloads, even over a running operation.
  always_comb begin
    cnt_d = cnt_q;
    if (md_start_E) begin
      cnt_d = md_is_div_E ? c_DIV_LOAD : c_MULT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] perf_q;
  logic [31:0] perf_d;

  assign perf_d = stall ? (perf_q + 32'd1) : perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign stall_cnt = perf_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Scoreboard bench for hazard_ctrl with a table-driven reference.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic       reset;
    logic [4:0] rs_D, rt_D, rs_E, rt_E, dst_E, dst_M, dst_W, rt_M;
    logic [1:0] tuse_rs_D, tuse_rt_D;
    logic [2:0] res_E, res_M, res_W;
    logic       md_instr_D, md_start_E, md_is_div_E;
  } in_t;

  typedef struct {
    int stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy;
    logic [31:0] stall_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, rs_E, rt_E, dst_E, dst_M, dst_W, rt_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D;
  logic [2:0]  res_E, res_M, res_W;
  logic        md_instr_D, md_start_E, md_is_div_E;
  logic        stall, en_PC, en_D, flush_E, fwd_rt_M, md_busy;
  logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .md_instr_D(md_instr_D),
    .rs_E(rs_E), .rt_E(rt_E), .dst_E(dst_E),
    .res_E(res_E), .res_M(res_M), .res_W(res_W),
    .dst_M(dst_M), .dst_W(dst_W), .rt_M(rt_M),
    .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
    .stall(stall), .en_PC(en_PC), .en_D(en_D), .flush_E(flush_E),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  // Cycles until a producer's result exists, indexed [stage E/M/W][type].
  int tn_tab [3][8] = '{'{0, 1, 2, 0, 1, 0, 0, 0},
                        '{0, 0, 1, 0, 0, 0, 0, 0},
                        '{0, 0, 0, 0, 0, 0, 0, 0}};

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  bit          started = 0;
  bit          stim_done = 0;
  int          cyc = 0;
  int          busy_until = -1;
  logic [31:0] perf_model = 32'd0;

  function automatic void youngest(input logic [4:0] r, input int first, input in_t v,
                                   output bit found, output int stage, output int tn);
    logic [4:0] d [3];
    int         t [3];
    d[0] = v.dst_E; d[1] = v.dst_M; d[2] = v.dst_W;
    t[0] = int'(v.res_E); t[1] = int'(v.res_M); t[2] = int'(v.res_W);
    found = 0; stage = 0; tn = 0;
    for (int k = first; k < 3; k++) begin
      if (!found && r != 0 && d[k] == r && t[k] >= 1 && t[k] <= 4) begin
        found = 1; stage = k; tn = tn_tab[k][t[k]];
      end
    end
  endfunction

  // Forward code is stage+1 (E=1, M=2, W=3) once the value exists.
  function automatic void d_model(input logic [4:0] r, input logic [1:0] tuse, input in_t v,
                                  output int stl, output int sel);
    bit f; int st, tn;
    youngest(r, 0, v, f, st, tn);
    stl = (f && int'(tuse) != 3 && tn > int'(tuse)) ? 1 : 0;
    sel = (f && tn == 0) ? st + 1 : 0;
  endfunction

  function automatic int e_model(input logic [4:0] r, input in_t v);
    bit f; int st, tn;
    youngest(r, 1, v, f, st, tn);
    return (f && tn == 0) ? st + 1 : 0;
  endfunction

  function automatic in_t zero_vec();
    in_t v;
    v.reset = 0; v.rs_D = 0; v.rt_D = 0; v.rs_E = 0; v.rt_E = 0;
    v.dst_E = 0; v.dst_M = 0; v.dst_W = 0; v.rt_M = 0;
    v.tuse_rs_D = 3; v.tuse_rt_D = 3;
    v.res_E = 0; v.res_M = 0; v.res_W = 0;
    v.md_instr_D = 0; v.md_start_E = 0; v.md_is_div_E = 0;
    return v;
  endfunction

  function automatic in_t rand_vec();
    in_t v;
    v.reset = ($urandom_range(0, 63) == 0);
    v.rs_D = 5'($urandom_range(0, 3)); v.rt_D = 5'($urandom_range(0, 3));
    v.rs_E = 5'($urandom_range(0, 3)); v.rt_E = 5'($urandom_range(0, 3));
    v.dst_E = 5'($urandom_range(0, 3)); v.dst_M = 5'($urandom_range(0, 3));
    v.dst_W = 5'($urandom_range(0, 3)); v.rt_M = 5'($urandom_range(0, 3));
    v.tuse_rs_D = 2'($urandom_range(0, 3)); v.tuse_rt_D = 2'($urandom_range(0, 3));
    v.res_E = 3'($urandom_range(0, 7)); v.res_M = 3'($urandom_range(0, 7));
    v.res_W = 3'($urandom_range(0, 7));
    v.md_instr_D = ($urandom_range(0, 3) == 0);
    v.md_start_E = ($urandom_range(0, 11) == 0);
    v.md_is_div_E = $urandom_range(0, 1) == 1;
    return v;
  endfunction

  task automatic drive(input in_t v);
    reset = v.reset; rs_D = v.rs_D; rt_D = v.rt_D; rs_E = v.rs_E; rt_E = v.rt_E;
    dst_E = v.dst_E; dst_M = v.dst_M; dst_W = v.dst_W; rt_M = v.rt_M;
    tuse_rs_D = v.tuse_rs_D; tuse_rt_D = v.tuse_rt_D;
    res_E = v.res_E; res_M = v.res_M; res_W = v.res_W;
    md_instr_D = v.md_instr_D; md_start_E = v.md_start_E; md_is_div_E = v.md_is_div_E;
  endtask

  task automatic apply(input in_t v);
    exp_t e;
    int   s1, s2;
    @(posedge clk);
    #1;
    drive(v);
    started = 1;
    d_model(v.rs_D, v.tuse_rs_D, v, s1, e.fwd_rs_D);
    d_model(v.rt_D, v.tuse_rt_D, v, s2, e.fwd_rt_D);
    e.fwd_rs_E = e_model(v.rs_E, v);
    e.fwd_rt_E = e_model(v.rt_E, v);
    e.fwd_rt_M = (v.rt_M != 0 && v.rt_M == v.dst_W && v.res_W >= 1 && v.res_W <= 4) ? 1 : 0;
    e.md_busy  = (v.md_start_E || cyc <= busy_until) ? 1 : 0;
    e.stall    = (s1 == 1 || s2 == 1 || (v.md_instr_D && e.md_busy == 1)) ? 1 : 0;
`ifdef HAZ_PERF_EN
    e.stall_cnt = perf_model;
`else
    e.stall_cnt = 32'd0;
`endif
    sb.push_back(e);
    if (v.reset) begin
      busy_until = -1;
      perf_model = 32'd0;
    end else begin
      if (v.md_start_E) busy_until = cyc + (v.md_is_div_E ? DIV_N : MULT_N);
      if (e.stall == 1) perf_model = perf_model + 32'd1;
    end
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   idle;
    idle = 0;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        idle = 0;
        chk("stall", int'(stall), e.stall);
        chk("en_PC", int'(en_PC), 1 - e.stall);
        chk("en_D", int'(en_D), 1 - e.stall);
        chk("flush_E", int'(flush_E), e.stall);
        chk("fwd_rs_D", int'(fwd_rs_D), e.fwd_rs_D);
        chk("fwd_rt_D", int'(fwd_rt_D), e.fwd_rt_D);
        chk("fwd_rs_E", int'(fwd_rs_E), e.fwd_rs_E);
        chk("fwd_rt_E", int'(fwd_rt_E), e.fwd_rt_E);
        chk("fwd_rt_M", int'(fwd_rt_M), e.fwd_rt_M);
        chk("md_busy", int'(md_busy), e.md_busy);
        chk("stall_cnt", int'(stall_cnt), int'(e.stall_cnt));
      end else if (stim_done) begin
        break;
      end else if (started) begin
        idle++;
        if (idle > 20) begin
          total++;
          bad++;
          $display("FAIL scoreboard_timeout idle=%0d expected=0", idle);
          break;
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stimulus
    in_t v;
    v = zero_vec();
    v.reset = 1;
    drive(v);
    repeat (2) @(posedge clk);

    apply(v);

    // Load-use, then the load moves to M and later W.
    v = zero_vec(); v.res_E = 3'd2; v.dst_E = 5; v.rs_D = 5; v.tuse_rs_D = 1; apply(v);
    v = zero_vec(); v.res_M = 3'd2; v.dst_M = 5; v.rs_D = 5; v.tuse_rs_D = 1; apply(v);
    v = zero_vec(); v.res_W = 3'd2; v.dst_W = 5; v.rs_E = 5; apply(v);
    // Branch after ALU: producer in E, then in M.
    v = zero_vec(); v.res_E = 3'd1; v.dst_E = 8; v.rt_D = 8; v.tuse_rt_D = 0; apply(v);
    v = zero_vec(); v.res_M = 3'd1; v.dst_M = 8; v.rt_D = 8; v.tuse_rt_D = 0; apply(v);
    // jal link forwarded from E.
    v = zero_vec(); v.res_E = 3'd3; v.dst_E = 31; v.rs_D = 31; v.tuse_rs_D = 0; apply(v);
    // Same register in every stage: youngest wins.
    v = zero_vec(); v.res_E = 3'd1; v.res_M = 3'd1; v.res_W = 3'd1;
    v.dst_E = 3; v.dst_M = 3; v.dst_W = 3; v.rs_D = 3; v.tuse_rs_D = 1;
    v.rs_E = 3; v.rt_E = 3; v.rt_M = 3; apply(v);
    // Register 0 is never a dependency.
    v = zero_vec(); v.res_E = 3'd2; v.rs_D = 0; v.tuse_rs_D = 0; apply(v);
    // Types 5-7 are not producers.
    v = zero_vec(); v.res_E = 3'd6; v.dst_E = 4; v.rs_D = 4; v.tuse_rs_D = 0;
    v.res_W = 3'd7; v.dst_W = 4; v.rt_M = 4; apply(v);

    // Divide busy window with the MD instruction waiting in D.
    v = zero_vec(); v.reset = 1; apply(v);
    v = zero_vec(); v.md_start_E = 1; v.md_is_div_E = 1; v.md_instr_D = 1; apply(v);
    v.md_start_E = 0; v.md_is_div_E = 0;
    repeat (DIV_N + 1) apply(v);
    v = zero_vec(); apply(v);

    // Multiply reload over a running divide, then reset mid-busy with a start.
    v = zero_vec(); v.md_start_E = 1; v.md_is_div_E = 1; apply(v);
    v = zero_vec(); repeat (3) apply(v);
    v.md_start_E = 1; apply(v);
    v = zero_vec(); v.md_instr_D = 1; repeat (3) apply(v);
    v.reset = 1; v.md_start_E = 1; apply(v);
    v = zero_vec(); v.md_instr_D = 1; repeat (2) apply(v);

    for (int i = 0; i < 600; i++) begin
      v = rand_vec();
      apply(v);
    end

    @(posedge clk);
    stim_done = 1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time=%0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer of the pipeline hazard tags (source/destination register numbers plus 3-bit result-type code) carried by the D/E/M/W stage registers.
- Compares D- and E-stage operand needs against E/M/W producer tags.
- Generates the stall/flush enables that drive those stage registers and the forwarding mux selects.
- Tracks a multi-cycle mult/div unit busy window with an internal down-counter.

Parameters:
- MULT_CYC, 5, busy cycles loaded for mult/multu.
- DIV_CYC, 10, busy cycles loaded for div/divu.
- CNT_W, 4, busy counter width; must hold DIV_CYC.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rs_D, rt_D  in  5 each  source registers in D
- tuse_rs_D, tuse_rt_D  in  2 each  cycles until operand needed: 0=D (branch/jr), 1=E, 2=M (store data), 3=unused
- md_instr_D  in  1  D instruction uses the mult/div unit (mult/div/mfhi/mflo/mthi/mtlo)
- rs_E, rt_E, dst_E  in  5 each  E-stage sources and destination
- res_E, res_M, res_W  in  3 each  result type: 0=NW, 1=ALU, 2=DM, 3=PC (link PC+8), 4=MD (mfhi/mflo); 5-7 treated as NW
- dst_M, dst_W, rt_M  in  5 each
- md_start_E  in  1  mult/div issuing from E this cycle
- md_is_div_E  in  1  the issuing op is a divide
- stall  out  1  hazard detected
- en_PC, en_D  out  1 each  = ~stall
- flush_E  out  1  = stall (bubble into E)
- fwd_rs_D, fwd_rt_D  out  2 each  0=no forward, 1=E (PC+8), 2=M, 3=W
- fwd_rs_E, fwd_rt_E  out  2 each  0=none, 2=M, 3=W (1 never driven)
- fwd_rt_M  out  1  store data from W
- md_busy  out  1
- stall_cnt  out  32  perf counter (see Optional Feature)

Behaviour:
- Tnew by stage and type:
  - E: ALU=1, DM=2, PC=0, MD=1.
  - M: ALU=0, DM=1, PC=0, MD=0.
  - W: all types 0.
  - NW: never a producer.
- Match condition: producer dst != 0, dst equals operand register, producer type not NW.
- Data stall: for operand X with tuse != 3, the youngest matching producer (E, then M, then W) has Tnew > tuse. Older matches are ignored once a younger one matches.
- Forward selects (D operands, youngest match wins):
  - E when res_E=PC.
  - M when res_M in {ALU, PC, MD}.
  - W for any non-NW type.
  - A match whose value is not yet ready gives sel 0; the stall covers that case.
  - fwd_rs_E/rt_E: M then W, same readiness rules.
  - fwd_rt_M: rt_M matches dst_W and res_W is not NW.
- Register 0 never forwards and never stalls.
- Mult/div counter:
  - Reset to 0.
  - On md_start_E, load MULT_CYC or DIV_CYC (md_is_div_E); reload even if non-zero.
  - Otherwise decrement while non-zero.
  - md_busy = (cnt != 0) | md_start_E.
- MD stall: md_instr_D & md_busy.
- stall = data stall | MD stall. It is purely combinational from the inputs and cnt, with zero-cycle latency.
- Reset: cnt=0. With all tags 0, stall=0, en_PC=en_D=1, flush_E=0, all fwd=0. Reset mid-busy clears cnt in the same edge.
- Simultaneous md_start_E with reset: reset wins.

Optional Feature:
- Macro HAZ_PERF_EN.
- Defined: 32-bit stall_cnt increments each cycle stall=1, wraps 0xFFFFFFFF->0, cleared by reset.
- Undefined: no counter logic; stall_cnt tied to 0.

Test Plan:
- Load-use: res_E=DM, dst_E=5, rs_D=5, tuse_rs_D=1 -> stall=1, en_D=0, flush_E=1. Next cycle with res_E=0, res_M=DM, dst_M=5 -> stall=0, fwd_rs_D=0, fwd_rs_E later=3 from W.
- Branch after ALU: res_E=ALU, dst_E=8, rt_D=8, tuse_rt_D=0 -> stall=1. With the producer in M instead -> stall=0, fwd_rt_D=2.
- jal link: res_E=PC, dst_E=31, rs_D=31, tuse=0 -> stall=0, fwd_rs_D=1.
- Priority: dst_E=dst_M=dst_W=3, all ALU, rs_D=3, tuse=1 -> stall=0, fwd_rs_D=0 (E match not ready, no stall since Tnew=1<=1). Later E-stage read picks M.
- Reg 0: dst_E=0, res_E=DM, rs_D=0, tuse=0 -> stall=0, fwd=0.
- Div: md_start_E=1, md_is_div_E=1, then md_instr_D=1 held -> stall=1 for 11 cycles (start cycle plus 10). With HAZ_PERF_EN, stall_cnt=11.
